// File: rtl/pipeline_stall_ctrl.sv
// Hazard and stall sequencer for the 5-stage pipeline: generates per-stage hold/bubble/kill
// controls combinationally from the current state, and keeps a saturating stall-cycle count.
module pipeline_stall_ctrl #(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       i_id_reg_rs1,
  input  logic [4:0]       i_id_reg_rs2,
  input  logic             i_id_uses_rs1,
  input  logic             i_id_uses_rs2,
  input  logic             i_id_serialize,
  input  logic             i_ex_load,
  input  logic [4:0]       i_ex_reg_rd,
  input  logic             i_ex_redirect,
  input  logic             i_ex_panic,
  input  logic             i_icache_miss,
  input  logic             i_dcache_req,
  input  logic             i_dcache_ready,
  output logic             o_pc_hold,
  output logic             o_ifid_hold,
  output logic             o_ifid_bubble,
  output logic             o_idex_hold,
  output logic             o_idex_bubble,
  output logic             o_exmem_hold,
  output logic             o_memwb_bubble,
  output logic             o_icache_kill,
  output logic             o_halted,
  output logic [CNT_W-1:0] o_stall_count
);

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_RUN   = 3'd0,
    ST_DWAIT = 3'd1,
    ST_IWAIT = 3'd2,
    ST_DRAIN = 3'd3,
    ST_HALT  = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [DW-1:0]    r_drain_cnt;
  logic [DW-1:0]    w_drain_next;
  logic [CNT_W-1:0] r_stall_count;

  logic w_dmiss;
  logic w_load_use;
  logic w_halt;
  logic w_pc_hold, w_ifid_hold, w_ifid_bubble, w_idex_hold, w_idex_bubble;
  logic w_exmem_hold, w_memwb_bubble, w_icache_kill;
  logic w_count_en;

  assign w_dmiss    = i_dcache_req & ~i_dcache_ready;
  assign w_load_use = i_ex_load & (i_ex_reg_rd != 5'd0) &
                      ((i_id_uses_rs1 & (i_id_reg_rs1 == i_ex_reg_rd)) |
                       (i_id_uses_rs2 & (i_id_reg_rs2 == i_ex_reg_rd)));

  always_comb begin
    w_next         = ST_RUN;
    w_drain_next   = '0;
    w_halt         = 1'b0;
    w_pc_hold      = 1'b0;
    w_ifid_hold    = 1'b0;
    w_ifid_bubble  = 1'b0;
    w_idex_hold    = 1'b0;
    w_idex_bubble  = 1'b0;
    w_exmem_hold   = 1'b0;
    w_memwb_bubble = 1'b0;
    w_icache_kill  = 1'b0;
    if ((r_state == ST_HALT) || i_ex_panic) begin
      w_next         = ST_HALT;
      w_halt         = 1'b1;
      w_pc_hold      = 1'b1;
      w_ifid_hold    = 1'b1;
      w_idex_hold    = 1'b1;
      w_exmem_hold   = 1'b1;
      w_memwb_bubble = 1'b1;
    end else if (w_dmiss) begin
      // Redirects are deliberately ignored here; the branch stays in EX and re-asserts.
      w_next         = ST_DWAIT;
      w_pc_hold      = 1'b1;
      w_ifid_hold    = 1'b1;
      w_idex_hold    = 1'b1;
      w_exmem_hold   = 1'b1;
      w_memwb_bubble = 1'b1;
    end else if (i_ex_redirect) begin
      w_next        = ST_RUN;
      w_ifid_bubble = 1'b1;
      w_idex_bubble = 1'b1;
      w_icache_kill = (r_state == ST_IWAIT) | i_icache_miss;
    end else if (r_state == ST_DRAIN) begin
      if (r_drain_cnt != '0) begin
        w_next        = ST_DRAIN;
        w_drain_next  = r_drain_cnt - DW'(1);
        w_pc_hold     = 1'b1;
        w_ifid_hold   = 1'b1;
        w_idex_bubble = 1'b1;
      end else if (i_icache_miss) begin
        // Serialising instruction leaves ID, but nothing valid has been fetched behind it.
        w_next        = ST_IWAIT;
        w_pc_hold     = 1'b1;
        w_ifid_bubble = 1'b1;
      end else begin
        w_next = ST_RUN;
      end
    end else if (w_load_use) begin
      // The ID instruction must stay put, so an I-miss cannot bubble IF/ID this cycle.
      w_next        = i_icache_miss ? ST_IWAIT : ST_RUN;
      w_pc_hold     = 1'b1;
      w_ifid_hold   = 1'b1;
      w_idex_bubble = 1'b1;
    end else if (i_id_serialize) begin
      w_next        = ST_DRAIN;
      w_drain_next  = DRAIN_LOAD;
      w_pc_hold     = 1'b1;
      w_ifid_hold   = 1'b1;
      w_idex_bubble = 1'b1;
    end else if (i_icache_miss) begin
      w_next        = ST_IWAIT;
      w_pc_hold     = 1'b1;
      w_ifid_bubble = 1'b1;
    end else begin
      w_next = ST_RUN;
    end
  end

  assign w_count_en = ~w_halt & (w_pc_hold | w_ifid_hold | w_ifid_bubble | w_idex_hold |
                                 w_idex_bubble | w_exmem_hold | w_memwb_bubble);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= ST_RUN;
      r_drain_cnt   <= '0;
      r_stall_count <= '0;
    end else begin
      r_state     <= w_next;
      r_drain_cnt <= w_drain_next;
      if (w_count_en && (r_stall_count != {CNT_W{1'b1}})) begin
        r_stall_count <= r_stall_count + CNT_W'(1);
      end
    end
  end

  // Controls are forced low for the whole time reset is held.
  assign o_pc_hold      = ~reset & w_pc_hold;
  assign o_ifid_hold    = ~reset & w_ifid_hold;
  assign o_ifid_bubble  = ~reset & w_ifid_bubble;
  assign o_idex_hold    = ~reset & w_idex_hold;
  assign o_idex_bubble  = ~reset & w_idex_bubble;
  assign o_exmem_hold   = ~reset & w_exmem_hold;
  assign o_memwb_bubble = ~reset & w_memwb_bubble;
  assign o_icache_kill  = ~reset & w_icache_kill;
  assign o_halted       = ~reset & w_halt;
  assign o_stall_count  = r_stall_count;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed bench for pipeline_stall_ctrl (DRAIN_CYCLES=3, CNT_W=4) with hand-computed expectations.
module tb_pipeline_stall_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] id_reg_rs1, id_reg_rs2, ex_reg_rd;
  logic       id_uses_rs1, id_uses_rs2, id_serialize, ex_load, ex_redirect, ex_panic;
  logic       icache_miss, dcache_req, dcache_ready;
  logic       pc_hold, ifid_hold, ifid_bubble, idex_hold, idex_bubble;
  logic       exmem_hold, memwb_bubble, icache_kill, halted;
  logic [3:0] stall_count;
  logic [8:0] outs;

  int checks   = 0;
  int failures = 0;

  // {pc_hold, ifid_hold, ifid_bubble, idex_hold, idex_bubble, exmem_hold, memwb_bubble, icache_kill, halted}
  localparam logic [8:0] NONE = 9'b000000000;
  localparam logic [8:0] LU   = 9'b110010000;
  localparam logic [8:0] DR   = 9'b110010000;
  localparam logic [8:0] DM   = 9'b110101100;
  localparam logic [8:0] RD   = 9'b001010000;
  localparam logic [8:0] RDK  = 9'b001010010;
  localparam logic [8:0] IM   = 9'b101000000;
  localparam logic [8:0] HLT  = 9'b110101101;

  always #5 clk = ~clk;

  assign outs = {pc_hold, ifid_hold, ifid_bubble, idex_hold, idex_bubble,
                 exmem_hold, memwb_bubble, icache_kill, halted};

  pipeline_stall_ctrl #(.DRAIN_CYCLES(3), .CNT_W(4)) dut (
    .clk(clk), .reset(reset),
    .i_id_reg_rs1(id_reg_rs1), .i_id_reg_rs2(id_reg_rs2),
    .i_id_uses_rs1(id_uses_rs1), .i_id_uses_rs2(id_uses_rs2),
    .i_id_serialize(id_serialize), .i_ex_load(ex_load), .i_ex_reg_rd(ex_reg_rd),
    .i_ex_redirect(ex_redirect), .i_ex_panic(ex_panic), .i_icache_miss(icache_miss),
    .i_dcache_req(dcache_req), .i_dcache_ready(dcache_ready),
    .o_pc_hold(pc_hold), .o_ifid_hold(ifid_hold), .o_ifid_bubble(ifid_bubble),
    .o_idex_hold(idex_hold), .o_idex_bubble(idex_bubble), .o_exmem_hold(exmem_hold),
    .o_memwb_bubble(memwb_bubble), .o_icache_kill(icache_kill), .o_halted(halted),
    .o_stall_count(stall_count)
  );

  task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_cnt(input string tag, input logic [3:0] exp);
    checks++;
    assert (stall_count === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, stall_count, exp);
    end
  endtask

  task automatic clear_in();
    id_reg_rs1 = 5'd0; id_reg_rs2 = 5'd0; ex_reg_rd = 5'd0;
    id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; id_serialize = 1'b0;
    ex_load = 1'b0; ex_redirect = 1'b0; ex_panic = 1'b0;
    icache_miss = 1'b0; dcache_req = 1'b0; dcache_ready = 1'b0;
  endtask

  // New step: inputs change just after the falling edge.
  task automatic step();
    @(negedge clk);
    clear_in();
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    clear_in();
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  initial begin
    clear_in();
    reset = 1'b1;
    dcache_req = 1'b1; ex_redirect = 1'b1; icache_miss = 1'b1;
    #3;
    chk("reset_outs", outs, NONE);
    chk_cnt("reset_cnt", 4'd0);
    @(negedge clk); @(negedge clk);
    clear_in();
    reset = 1'b0;

    // Load-use via rs2, one cycle only
    step(); ex_load = 1'b1; ex_reg_rd = 5'd5; id_uses_rs2 = 1'b1; id_reg_rs2 = 5'd5;
    id_uses_rs1 = 1'b1; id_reg_rs1 = 5'd3; #1;
    chk("loaduse_rs2", outs, LU);
    step(); #1;
    chk("loaduse_after", outs, NONE);
    chk_cnt("loaduse_cnt", 4'd1);
    step(); ex_load = 1'b1; ex_reg_rd = 5'd0; id_uses_rs2 = 1'b1; id_reg_rs2 = 5'd0; #1;
    chk("loaduse_rd0", outs, NONE);
    step(); ex_load = 1'b1; ex_reg_rd = 5'd7; id_reg_rs1 = 5'd7; id_uses_rs1 = 1'b0;
    id_uses_rs2 = 1'b1; id_reg_rs2 = 5'd2; #1;
    chk("loaduse_unused_rs1", outs, NONE);
    step(); ex_load = 1'b1; ex_reg_rd = 5'd9; id_reg_rs1 = 5'd9; id_uses_rs1 = 1'b1; #1;
    chk("loaduse_rs1", outs, LU);
    step(); #1;
    chk_cnt("loaduse_cnt2", 4'd2);

    // D-miss for 4 cycles then release
    pulse_reset();
    for (int i = 0; i < 4; i++) begin
      step(); dcache_req = 1'b1; #1;
      chk($sformatf("dmiss_c%0d", i), outs, DM);
    end
    step(); dcache_req = 1'b1; dcache_ready = 1'b1; #1;
    chk("dmiss_release", outs, NONE);
    step(); #1;
    chk_cnt("dmiss_cnt", 4'd4);

    // Redirect during a D-miss is deferred to the release cycle
    pulse_reset();
    step(); dcache_req = 1'b1; #1;
    chk("dmiss_redir_c0", outs, DM);
    step(); dcache_req = 1'b1; ex_redirect = 1'b1; #1;
    chk("dmiss_redir_masked", outs, DM);
    step(); dcache_req = 1'b1; dcache_ready = 1'b1; ex_redirect = 1'b1; #1;
    chk("dmiss_redir_release", outs, RD);
    step(); #1;
    chk("dmiss_redir_after", outs, NONE);

    // Redirect after an I-miss kills the fetch
    pulse_reset();
    step(); icache_miss = 1'b1; #1;
    chk("imiss_c0", outs, IM);
    step(); icache_miss = 1'b1; #1;
    chk("imiss_c1", outs, IM);
    step(); ex_redirect = 1'b1; #1;
    chk("imiss_redirect_kill", outs, RDK);
    step(); ex_redirect = 1'b1; #1;
    chk("redirect_in_run_nokill", outs, RD);
    step(); icache_miss = 1'b1; ex_redirect = 1'b1; #1;
    chk("redirect_with_miss_kill", outs, RDK);

    // Serialise: three held cycles then release
    pulse_reset();
    step(); id_serialize = 1'b1; #1;
    chk("ser_entry", outs, DR);
    step(); id_serialize = 1'b1; #1;
    chk("ser_drain2", outs, DR);
    step(); id_serialize = 1'b1; #1;
    chk("ser_drain1", outs, DR);
    step(); id_serialize = 1'b1; #1;
    chk("ser_release", outs, NONE);
    step(); id_serialize = 1'b1; #1;
    chk("ser_reenter", outs, DR);
    chk_cnt("ser_cnt", 4'd3);
    step(); id_serialize = 1'b1; ex_redirect = 1'b1; #1;
    chk("ser_abort_redirect", outs, RD);
    step(); #1;
    chk("ser_aborted", outs, NONE);
    chk_cnt("ser_abort_cnt", 4'd5);

    // Load-use wins over serialise; drain starts one cycle later
    pulse_reset();
    step(); id_serialize = 1'b1; ex_load = 1'b1; ex_reg_rd = 5'd4;
    id_reg_rs1 = 5'd4; id_uses_rs1 = 1'b1; #1;
    chk("lu_ser_lu", outs, LU);
    for (int i = 0; i < 3; i++) begin
      step(); id_serialize = 1'b1; #1;
      chk($sformatf("lu_ser_drain%0d", i), outs, DR);
    end
    step(); id_serialize = 1'b1; #1;
    chk("lu_ser_release", outs, NONE);

    // Panic halts until reset; counter frozen
    pulse_reset();
    step(); ex_load = 1'b1; ex_reg_rd = 5'd1; id_reg_rs1 = 5'd1; id_uses_rs1 = 1'b1; #1;
    chk("pre_panic_lu", outs, LU);
    step(); ex_panic = 1'b1; #1;
    chk("panic_cycle", outs, HLT);
    step(); ex_redirect = 1'b1; #1;
    chk("halt_redirect", outs, HLT);
    step(); dcache_req = 1'b1; #1;
    chk("halt_dmiss", outs, HLT);
    step(); #1;
    chk("halt_idle", outs, HLT);
    chk_cnt("halt_cnt_frozen", 4'd1);
    reset = 1'b1; #1;
    chk("halt_reset_outs", outs, NONE);
    chk_cnt("halt_reset_cnt", 4'd0);
    reset = 1'b0;
    step(); #1;
    chk("after_halt_run", outs, NONE);

    // Saturation at 15 with a 4-bit counter
    pulse_reset();
    for (int i = 0; i < 20; i++) begin
      step(); dcache_req = 1'b1;
    end
    step(); #1;
    chk_cnt("sat_20", 4'd15);
    step(); icache_miss = 1'b1;
    step(); #1;
    chk_cnt("sat_hold", 4'd15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
